// File: rtl/token_window_counter_if.sv
// Token input and window-count output bundle for token_window_counter.
// slave = counter side, master = producer/consumer side.
interface token_window_counter_if #(
    parameter int OUT_W = 8
);
    logic             a;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_count;
    logic             drop;

    modport master (
        output a,
        output out_ready,
        input  out_valid,
        input  out_count,
        input  drop
    );

    modport slave (
        input  a,
        input  out_ready,
        output out_valid,
        output out_count,
        output drop
    );
endinterface

// File: rtl/token_window_counter.sv
// Counts '1' tokens over WINDOW-cycle windows; each window count is presented 1 cycle after close on valid/ready.
// Full output stage discards the new count and pulses drop; TOKEN_WINDOW_SKID_EN makes the stage a 2-entry FIFO.
module token_window_counter #(
    parameter int WINDOW = 16,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    token_window_counter_if.slave bus
);
    localparam int CYC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ACC_W = $clog2(WINDOW + 1);
    localparam logic [32:0] SAT_MAX = (33'd1 << OUT_W) - 33'd1;

    logic [CYC_W-1:0] r_cyc;
    logic [ACC_W-1:0] r_acc;
    logic             w_close;
    logic [32:0]      w_sum;
    logic [OUT_W-1:0] w_fin;

    assign w_close = (r_cyc == CYC_W'(WINDOW - 1));
    // The close-cycle token belongs to the closing window, so fold it in before saturating.
    assign w_sum   = 33'(r_acc) + 33'(bus.a);
    assign w_fin   = (w_sum > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : w_sum[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
            r_acc <= '0;
        end else if (w_close) begin
            r_cyc <= '0;
            r_acc <= '0;
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
            r_acc <= r_acc + ACC_W'(bus.a);
        end
    end

`ifdef TOKEN_WINDOW_SKID_EN
    logic [OUT_W-1:0] r_q0;
    logic [OUT_W-1:0] r_q1;
    logic [1:0]       r_n;
    logic             r_drop;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = (r_n != 2'd0) && bus.out_ready;
    assign w_push = w_close && ((r_n != 2'd2) || w_pop);

    // r_q0 is the head; it only shifts when a second entry is waiting, so an
    // emptied FIFO keeps showing the last count handed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q0   <= '0;
            r_q1   <= '0;
            r_n    <= 2'd0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_close && !w_push;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_n == 2'd0) r_q0 <= w_fin;
                    else             r_q1 <= w_fin;
                    r_n <= r_n + 2'd1;
                end
                2'b01: begin
                    if (r_n == 2'd2) r_q0 <= r_q1;
                    r_n <= r_n - 2'd1;
                end
                2'b11: begin
                    if (r_n == 2'd2) begin
                        r_q0 <= r_q1;
                        r_q1 <= w_fin;
                    end else begin
                        r_q0 <= w_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (r_n != 2'd0);
    assign bus.out_count = r_q0;
    assign bus.drop      = r_drop;
`else
    logic             r_vld;
    logic [OUT_W-1:0] r_cnt;
    logic             r_drop;
    logic             w_xfer;

    assign w_xfer = r_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_cnt  <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_close) begin
                if (!r_vld || w_xfer) begin
                    r_vld <= 1'b1;
                    r_cnt <= w_fin;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (w_xfer) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_vld;
    assign bus.out_count = r_cnt;
    assign bus.drop      = r_drop;
`endif
endmodule

// File: tb/tb_token_window_counter.sv
// Drives two counters (WINDOW=4/OUT_W=8 and WINDOW=8/OUT_W=2) and compares them every cycle
// against a queue-of-window-counts reference model.
module tb_token_window_counter;
`ifdef TOKEN_WINDOW_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk;
    logic rst0;
    logic rst1;

    token_window_counter_if #(.OUT_W(8)) if0 ();
    token_window_counter_if #(.OUT_W(2)) if1 ();

    token_window_counter #(.WINDOW(4), .OUT_W(8)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0));
    token_window_counter #(.WINDOW(8), .OUT_W(2)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: per unit, the window position, the running token tally,
    // and the list of completed window counts waiting for the consumer.
    int  win_len [2] = '{4, 8};
    int  sat_max [2] = '{255, 3};
    int  pos     [2];
    int  tally   [2];
    int  pend    [2][2];
    int  npend   [2];
    int  last    [2];
    bit  edrop   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int u, input bit r, input bit a, input bit rdy);
        int fin;
        if (r) begin
            pos[u] = 0; tally[u] = 0; npend[u] = 0; last[u] = 0; edrop[u] = 0;
            return;
        end
        edrop[u] = 0;
        if (npend[u] > 0 && rdy) begin
            last[u]    = pend[u][0];
            pend[u][0] = pend[u][1];
            npend[u]--;
        end
        if (pos[u] == win_len[u] - 1) begin
            fin = tally[u] + int'(a);
            if (fin > sat_max[u]) fin = sat_max[u];
            if (npend[u] < DEPTH) begin
                pend[u][npend[u]] = fin;
                npend[u]++;
            end else begin
                edrop[u] = 1;
            end
            tally[u] = 0;
        end else begin
            tally[u] += int'(a);
        end
        pos[u] = (pos[u] + 1) % win_len[u];
    endtask

    task automatic tick(input string tag);
        bit r0, a0, y0, r1, a1, y1;
        @(posedge clk);
        r0 = rst0; a0 = if0.a; y0 = if0.out_ready;
        r1 = rst1; a1 = if1.a; y1 = if1.out_ready;
        model_step(0, r0, a0, y0);
        model_step(1, r1, a1, y1);
        #1;
        chk({tag, ".valid0"}, 32'(if0.out_valid), 32'(npend[0] > 0));
        chk({tag, ".count0"}, 32'(if0.out_count), (npend[0] > 0) ? pend[0][0] : last[0]);
        chk({tag, ".drop0"},  32'(if0.drop),      32'(edrop[0]));
        chk({tag, ".valid1"}, 32'(if1.out_valid), 32'(npend[1] > 0));
        chk({tag, ".count1"}, 32'(if1.out_count), (npend[1] > 0) ? pend[1][0] : last[1]);
        chk({tag, ".drop1"},  32'(if1.drop),      32'(edrop[1]));
    endtask

    task automatic drive0(input bit a, input bit rdy);
        if0.a = a;
        if0.out_ready = rdy;
    endtask

    initial begin
        bit pat [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
        int thr;

        rst0 = 1'b1; rst1 = 1'b1;
        drive0(1'b0, 1'b0);
        if1.a = 1'b1; if1.out_ready = 1'b1;
        tick("reset");
        tick("reset");
        rst0 = 1'b0; rst1 = 1'b0;

        // Constant tokens, always ready: one count of 4 per window, never dropped.
        drive0(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) tick("const_ones");

        // Partial window then empty window; both counts must be emitted.
        for (int i = 0; i < 8; i++) begin
            drive0(pat[i], 1'b1);
            tick("pattern");
        end

        // Consumer stalled across three closes, then drained.
        for (int i = 0; i < 12; i++) begin
            drive0(1'b1, 1'b0);
            tick("stall");
        end
        for (int i = 0; i < 8; i++) begin
            drive0(1'b0, 1'b1);
            tick("drain");
        end

        // Occupied slot being consumed on the close cycle: no drop, new count loaded.
        for (int i = 0; i < 4 && pos[0] != 0; i++) begin
            drive0(1'b0, 1'b1);
            tick("align");
        end
        for (int i = 0; i < 7; i++) begin
            drive0(1'b1, 1'b0);
            tick("hold");
        end
        drive0(1'b1, 1'b1);
        tick("close_xfer");
        drive0(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick("post_xfer");

        // Mid-window reset discards the partial count.
        drive0(1'b1, 1'b1);
        tick("pre_rst");
        tick("pre_rst");
        rst0 = 1'b1;
        tick("mid_rst");
        rst0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive0(i == 0, 1'b1);
            tick("post_rst");
        end
        for (int i = 0; i < 3; i++) tick("post_rst");

        // Random traffic with varying consumer readiness and occasional resets.
        for (int seg = 0; seg < 8; seg++) begin
            thr = $urandom_range(0, 4);
            for (int i = 0; i < 50; i++) begin
                drive0(1'($urandom_range(0, 1)), ($urandom_range(0, 3) < thr));
                rst0 = ($urandom_range(0, 99) == 0);
                if1.a = ($urandom_range(0, 3) != 0);
                if1.out_ready = ($urandom_range(0, 3) < thr);
                rst1 = ($urandom_range(0, 149) == 0);
                tick("random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
